// File: rtl/aurora_ctrl_mp.sv
// aurora_ctrl_mp: multi-beat tnet link controller; RX decode/queue/forward plus local TX over one Aurora AXIS pair.
// RX capture runs independently of the TX FSM so incoming beats are never lost.
module aurora_ctrl_mp #(
   parameter int DW         = 64,
   parameter int DATA_WORDS = 1,
   parameter int QD         = 4
) (
   input  logic                     user_clk_i,
   input  logic                     user_rst_ni,
   input  logic                     tx_req_ti,
   input  logic [DW-1:0]            tx_header_ti,
   input  logic [DATA_WORDS*DW-1:0] tx_data_ti,
   output logic                     tx_ack_uo,
   input  logic [9:0]               ID,
   input  logic [9:0]               NN,
   input  logic                     channel_ok_i,
   output logic                     ready_o,
   output logic                     cmd_valid_o,
   input  logic                     cmd_ready_i,
   output logic [DW-1:0]            cmd_header_o,
   output logic [DATA_WORDS*DW-1:0] cmd_data_o,
   output logic [$clog2(QD):0]      cmd_cnt_o,
   output logic [15:0]              drop_cnt_o,
   input  logic [DW-1:0]            s_axi_rx_tdata,
   input  logic                     s_axi_rx_tvalid,
   input  logic                     s_axi_rx_tlast,
   output logic [DW-1:0]            m_axi_tx_tdata,
   output logic                     m_axi_tx_tvalid,
   output logic                     m_axi_tx_tlast,
   input  logic                     m_axi_tx_tready,
   output logic [3:0]               debug_do
);
   localparam int AW = $clog2(QD);
   localparam int PW = DATA_WORDS * DW;
   localparam int BW = $clog2(DATA_WORDS + 1);

   typedef enum logic [2:0] {NOT_READY, IDLE, FWD_H, FWD_D, TX_H, TX_D, WAIT_NREQ} state_t;
   state_t state, nxt;

   logic req_q, req_s;
   logic [BW-1:0] bcnt, idx;
   logic skip, rx_done, rx_err, beat_last;
   logic [DW-1:0] st_hdr, pend_hdr, fwd_hdr, pd, td;
   logic [PW-1:0] st_data, pend_data;
   logic [9:0] dst, step;
   logic own, all, hop_ok, process, fwd, full, pop, push, drop_q, drop_f, pend_v, pend_free;
   logic hs, last_idx;
   logic [AW:0] wp, rp;
   logic [16:0] drop_sum;
   logic [DW-1:0] q_hdr [QD];
   logic [PW-1:0] q_data [QD];

   always_ff @(posedge user_clk_i or negedge user_rst_ni)
      if (!user_rst_ni) {req_s, req_q} <= '0;
      else {req_s, req_q} <= {req_q, tx_req_ti};

   always_comb begin
      beat_last = bcnt == BW'(DATA_WORDS);
      rx_err = s_axi_rx_tvalid && !skip && channel_ok_i && (beat_last ? !s_axi_rx_tlast : s_axi_rx_tlast);
   end

   // skip discards beats up to and including the next tlast after a missing-tlast error
   always_ff @(posedge user_clk_i or negedge user_rst_ni)
      if (!user_rst_ni) begin
         bcnt <= '0;
         skip <= 1'b0;
         rx_done <= 1'b0;
         st_hdr <= '0;
         st_data <= '0;
      end else if (!channel_ok_i) begin
         bcnt <= '0;
         skip <= 1'b0;
         rx_done <= 1'b0;
         st_hdr <= '0;
         st_data <= '0;
      end else begin
         rx_done <= 1'b0;
         if (s_axi_rx_tvalid && skip) skip <= !s_axi_rx_tlast;
         else if (s_axi_rx_tvalid) begin
            if (bcnt == '0) st_hdr <= s_axi_rx_tdata;
            for (int k = 0; k < DATA_WORDS; k++)
               if (bcnt == BW'(k + 1)) st_data[k*DW +: DW] <= s_axi_rx_tdata;
            bcnt <= (beat_last || s_axi_rx_tlast) ? '0 : bcnt + 1'b1;
            rx_done <= beat_last && s_axi_rx_tlast;
            skip <= beat_last && !s_axi_rx_tlast;
         end
      end

   always_comb begin
      dst = st_hdr[49:40];
      step = st_hdr[29:20];
      own = ID != '0 && dst == ID;
      all = &dst;
      hop_ok = NN == '0 || step < NN;
      process = rx_done && (own || all);
      fwd = rx_done && hop_ok && (!own || all);
      cmd_valid_o = wp != rp;
      cmd_cnt_o = wp - rp;
      full = cmd_cnt_o == ($clog2(QD)+1)'(QD);
      pop = cmd_valid_o && cmd_ready_i;
      push = process && (!full || pop);
      drop_q = process && full && !pop;
      drop_f = fwd && pend_v;
      drop_sum = {1'b0, drop_cnt_o} + 17'(rx_err) + 17'(drop_q) + 17'(drop_f);
      fwd_hdr = st_hdr;
      fwd_hdr[29:20] = step + 10'd1;
      cmd_header_o = cmd_valid_o ? q_hdr[rp[AW-1:0]] : '0;
      cmd_data_o = cmd_valid_o ? q_data[rp[AW-1:0]] : '0;
   end

   always_ff @(posedge user_clk_i)
      if (push) begin
         q_hdr[wp[AW-1:0]] <= st_hdr;
         q_data[wp[AW-1:0]] <= st_data;
      end

   always_ff @(posedge user_clk_i or negedge user_rst_ni)
      if (!user_rst_ni) begin
         wp <= '0;
         rp <= '0;
         drop_cnt_o <= '0;
      end else begin
         wp <= wp + (AW+1)'(push);
         rp <= rp + (AW+1)'(pop);
         drop_cnt_o <= drop_sum[16] ? '1 : drop_sum[15:0];
      end

   always_ff @(posedge user_clk_i or negedge user_rst_ni)
      if (!user_rst_ni) begin
         pend_v <= 1'b0;
         pend_hdr <= '0;
         pend_data <= '0;
      end else if (!channel_ok_i) begin
         pend_v <= 1'b0;
         pend_hdr <= '0;
         pend_data <= '0;
      end else if (fwd && !pend_v) begin
         pend_v <= 1'b1;
         pend_hdr <= fwd_hdr;
         pend_data <= st_data;
      end else if (pend_free) pend_v <= 1'b0;

   always_ff @(posedge user_clk_i or negedge user_rst_ni)
      if (!user_rst_ni) state <= NOT_READY;
      else state <= nxt;

   always_ff @(posedge user_clk_i or negedge user_rst_ni)
      if (!user_rst_ni) idx <= '0;
      else if ((state == FWD_D || state == TX_D) && hs) idx <= last_idx ? '0 : idx + 1'b1;
      else if (state != FWD_D && state != TX_D) idx <= '0;

   always_comb begin
      nxt = state;
      case (state)
         NOT_READY: nxt = IDLE;
         IDLE:      nxt = pend_v ? FWD_H : req_s ? TX_H : IDLE;
         FWD_H:     nxt = hs ? FWD_D : FWD_H;
         FWD_D:     nxt = hs && last_idx ? IDLE : FWD_D;
         TX_H:      nxt = hs ? TX_D : TX_H;
         TX_D:      nxt = hs && last_idx ? WAIT_NREQ : TX_D;
         WAIT_NREQ: nxt = req_s ? WAIT_NREQ : IDLE;
         default:   nxt = NOT_READY;
      endcase
      if (!channel_ok_i) nxt = NOT_READY;
   end

   always_comb begin
      pd = pend_data[int'(idx)*DW +: DW];
      td = tx_data_ti[int'(idx)*DW +: DW];
      last_idx = idx == BW'(DATA_WORDS - 1);
      m_axi_tx_tvalid = state inside {FWD_H, FWD_D, TX_H, TX_D};
      hs = m_axi_tx_tvalid && m_axi_tx_tready;
      pend_free = state == FWD_D && hs && last_idx;
      m_axi_tx_tlast = (state == FWD_D || state == TX_D) && last_idx;
      m_axi_tx_tdata = state == FWD_H ? pend_hdr : state == FWD_D ? pd :
                       state == TX_H ? tx_header_ti : state == TX_D ? td : '0;
      ready_o = state != NOT_READY;
      tx_ack_uo = state == TX_H || state == TX_D || (state == WAIT_NREQ && req_s);
      debug_do = {1'b0, state};
   end
endmodule

// File: tb/tb_aurora_ctrl_mp.sv
// tb_aurora_ctrl_mp: table-driven decode vectors plus hand sequences; TX beats and queue entries via scoreboards.
module tb_aurora_ctrl_mp;
   localparam int DW = 64, DWORDS = 2, QD = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic tx_req = 0, tx_ack, channel_ok = 0, ready, cmd_valid, cmd_ready = 0;
   logic [63:0] tx_hdr = '0, cmd_header, rx_data = '0, tx_data;
   logic [127:0] tx_pl = '0, cmd_data;
   logic [9:0] id = 10'd3, nn = '0;
   logic [2:0] cmd_cnt;
   logic [15:0] drop_cnt;
   logic rx_vld = 0, rx_last = 0, tx_vld, tx_last, tx_rdy = 1;
   logic [3:0] dbg;

   aurora_ctrl_mp #(.DW(DW), .DATA_WORDS(DWORDS), .QD(QD)) dut (
      .user_clk_i(clk), .user_rst_ni(rst_n), .tx_req_ti(tx_req), .tx_header_ti(tx_hdr),
      .tx_data_ti(tx_pl), .tx_ack_uo(tx_ack), .ID(id), .NN(nn), .channel_ok_i(channel_ok),
      .ready_o(ready), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_header_o(cmd_header),
      .cmd_data_o(cmd_data), .cmd_cnt_o(cmd_cnt), .drop_cnt_o(drop_cnt),
      .s_axi_rx_tdata(rx_data), .s_axi_rx_tvalid(rx_vld), .s_axi_rx_tlast(rx_last),
      .m_axi_tx_tdata(tx_data), .m_axi_tx_tvalid(tx_vld), .m_axi_tx_tlast(tx_last),
      .m_axi_tx_tready(tx_rdy), .debug_do(dbg)
   );

   typedef struct {logic [63:0] d; logic l;} beat_t;
   typedef struct {logic [63:0] h; logic [127:0] d;} cmd_t;
   typedef struct {logic [9:0] id, nn, dst, step; bit q, f;} vec_t;

   beat_t exp_tx[$];
   cmd_t exp_cmd[$];
   vec_t vt[10];
   int nchk = 0, nfail = 0, drop_exp = 0;

   task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", n, got, exp);
      end
   endtask

   always @(negedge clk)
      if (rst_n && tx_vld && tx_rdy) begin
         beat_t b;
         if (exp_tx.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL tx_unexpected got=%0h exp=none", tx_data);
         end else begin
            b = exp_tx.pop_front();
            chk("tx_data", tx_data, b.d);
            chk("tx_last", tx_last, b.l);
         end
      end

   task automatic chk_head();
      cmd_t c;
      if (exp_cmd.size() == 0) begin
         nchk++;
         nfail++;
         $display("FAIL cmd_underflow got=%0h exp=none", cmd_header);
      end else begin
         c = exp_cmd.pop_front();
         chk("cmd_valid", cmd_valid, 1);
         chk("cmd_hdr", cmd_header, c.h);
         chk("cmd_data", cmd_data, c.d);
      end
   endtask

   task automatic pop_cmd();
      @(negedge clk);
      chk_head();
      cmd_ready = 1;
      @(posedge clk); #1;
      cmd_ready = 0;
   endtask

   task automatic send_pkt(input logic [63:0] h, a, b, input bit early, input bit pop);
      @(posedge clk); #1;
      rx_vld = 1; rx_data = h; rx_last = 0;
      @(posedge clk); #1;
      rx_data = a; rx_last = early;
      @(posedge clk); #1;
      if (!early) begin
         rx_data = b; rx_last = 1;
         @(posedge clk); #1;
      end
      rx_vld = 0; rx_last = 0;
      if (pop) begin
         chk_head();
         cmd_ready = 1;
         @(posedge clk); #1;
         cmd_ready = 0;
      end
   endtask

   task automatic wait_tx(input int n);
      int k = 0;
      while (exp_tx.size() != 0 && k < n) begin
         @(negedge clk);
         k++;
      end
      chk("tx_drain_left", exp_tx.size(), 0);
   endtask

   task automatic wait_vld(input int n);
      int k = 0;
      @(negedge clk);
      while (!tx_vld && k < n) begin
         @(negedge clk);
         k++;
      end
      chk("tx_valid_wait", tx_vld, 1);
   endtask

   function automatic logic [63:0] mk_hdr(input logic [9:0] dst, step);
      logic [63:0] h = {$urandom, $urandom};
      h[49:40] = dst;
      h[29:20] = step;
      return h;
   endfunction

   task automatic push_fwd(input logic [63:0] h, a, b, input logic [9:0] nstep);
      logic [63:0] fh = h;
      fh[29:20] = nstep;
      exp_tx.push_back('{fh, 1'b0});
      exp_tx.push_back('{a, 1'b0});
      exp_tx.push_back('{b, 1'b1});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] h, a, b, lh, la, lb;
      vt[0] = '{10'd3, 10'd0, 10'd3,     10'd0,     1, 0};
      vt[1] = '{10'd3, 10'd8, 10'd5,     10'd2,     0, 1};
      vt[2] = '{10'd3, 10'd8, 10'd5,     10'd8,     0, 0};
      vt[3] = '{10'd3, 10'd8, 10'd5,     10'd7,     0, 1};
      vt[4] = '{10'd3, 10'd0, 10'h3FF,   10'd4,     1, 1};
      vt[5] = '{10'd3, 10'd8, 10'h3FF,   10'd9,     1, 0};
      vt[6] = '{10'd3, 10'd0, 10'd5,     10'h3FF,   0, 1};
      vt[7] = '{10'd3, 10'd0, 10'd0,     10'd0,     0, 1};
      vt[8] = '{10'd0, 10'd8, 10'd0,     10'd3,     0, 1};
      vt[9] = '{10'd3, 10'd8, 10'd3,     10'd9,     1, 0};

      repeat (2) @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_cnt", cmd_cnt, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_tvalid", tx_vld, 0);
      chk("rst_ack", tx_ack, 0);
      chk("rst_debug", dbg, 0);
      rst_n = 1;
      repeat (2) @(negedge clk);
      chk("noch_ready", ready, 0);
      channel_ok = 1;
      repeat (2) @(negedge clk);
      chk("up_ready", ready, 1);
      chk("up_debug", dbg, 1);

      foreach (vt[i]) begin
         id = vt[i].id;
         nn = vt[i].nn;
         h = mk_hdr(vt[i].dst, vt[i].step);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (vt[i].q) exp_cmd.push_back('{h, {b, a}});
         if (vt[i].f) push_fwd(h, a, b, vt[i].step + 10'd1);
         send_pkt(h, a, b, 0, 0);
         repeat (8) @(negedge clk);
         wait_tx(60);
         chk("vec_cmd_valid", cmd_valid, vt[i].q);
         if (vt[i].q) pop_cmd();
         chk("vec_drop", drop_cnt, drop_exp);
      end

      // broadcast under backpressure: tdata must hold while tready is low
      id = 10'd3; nn = 10'd0; tx_rdy = 0;
      h = mk_hdr(10'h3FF, 10'd1); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp_cmd.push_back('{h, {b, a}});
      push_fwd(h, a, b, 10'd2);
      send_pkt(h, a, b, 0, 0);
      wait_vld(20);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_tvalid", tx_vld, 1);
         chk("bp_tdata", tx_data, exp_tx[0].d);
      end
      @(posedge clk); #1;
      tx_rdy = 1;
      wait_tx(40);
      pop_cmd();

      // queue overflow, then simultaneous push+pop at full
      for (int k = 0; k < 5; k++) begin
         h = mk_hdr(10'd3, 10'(k)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
         if (k < 4) exp_cmd.push_back('{h, {b, a}});
         else drop_exp++;
         send_pkt(h, a, b, 0, 0);
      end
      repeat (3) @(negedge clk);
      chk("full_cnt", cmd_cnt, 4);
      chk("full_drop", drop_cnt, drop_exp);
      h = mk_hdr(10'd3, 10'd7); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp_cmd.push_back('{h, {b, a}});
      send_pkt(h, a, b, 0, 1);
      repeat (2) @(negedge clk);
      chk("pushpop_cnt", cmd_cnt, 4);
      chk("pushpop_drop", drop_cnt, drop_exp);
      for (int k = 0; k < 4; k++) pop_cmd();
      @(negedge clk);
      chk("drained", cmd_valid, 0);

      // forward takes priority over a concurrently pending local request
      nn = 10'd8;
      h = mk_hdr(10'd5, 10'd2); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      push_fwd(h, a, b, 10'd3);
      send_pkt(h, a, b, 0, 0);
      lh = {$urandom, $urandom}; la = {$urandom, $urandom}; lb = {$urandom, $urandom};
      tx_hdr = lh; tx_pl = {lb, la}; tx_req = 1;
      exp_tx.push_back('{lh, 1'b0});
      exp_tx.push_back('{la, 1'b0});
      exp_tx.push_back('{lb, 1'b1});
      wait_tx(80);
      repeat (2) @(negedge clk);
      chk("ack_wait", tx_ack, 1);
      tx_req = 0;
      @(negedge clk);
      chk("ack_1cyc", tx_ack, 1);
      @(negedge clk);
      chk("ack_2cyc", tx_ack, 0);

      // early tlast, then a clean packet
      nn = 10'd0;
      h = mk_hdr(10'd3, 10'd0); a = {$urandom, $urandom};
      drop_exp++;
      send_pkt(h, a, a, 1, 0);
      h = mk_hdr(10'd3, 10'd1); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp_cmd.push_back('{h, {b, a}});
      send_pkt(h, a, b, 0, 0);
      repeat (2) @(negedge clk);
      chk("early_drop", drop_cnt, drop_exp);
      chk("early_next_cnt", cmd_cnt, 1);

      // channel loss during the local data phase
      lh = {$urandom, $urandom};
      tx_hdr = lh; tx_rdy = 0; tx_req = 1;
      exp_tx.push_back('{lh, 1'b0});
      wait_vld(20);
      @(posedge clk); #1;
      tx_rdy = 1;
      @(posedge clk); #1;
      tx_rdy = 0;
      @(negedge clk);
      chk("txd_debug", dbg, 5);
      channel_ok = 0;
      @(negedge clk);
      chk("down_tvalid", tx_vld, 0);
      chk("down_debug", dbg, 0);
      chk("down_ready", ready, 0);
      chk("down_cnt", cmd_cnt, 1);
      tx_req = 0;
      repeat (3) @(negedge clk);
      channel_ok = 1;
      repeat (2) @(negedge clk);
      chk("reup_debug", dbg, 1);
      tx_rdy = 1;
      pop_cmd();
      wait_tx(10);

      // reset while a forward is stalled and the queue is non-empty
      tx_rdy = 0;
      send_pkt(mk_hdr(10'd3, 10'd0), 64'h1, 64'h2, 0, 0);
      send_pkt(mk_hdr(10'd5, 10'd0), 64'h3, 64'h4, 0, 0);
      wait_vld(20);
      chk("prerst_cnt", cmd_cnt, 1);
      rst_n = 0;
      #1;
      chk("midrst_tvalid", tx_vld, 0);
      chk("midrst_cnt", cmd_cnt, 0);
      chk("midrst_drop", drop_cnt, 0);
      chk("midrst_debug", dbg, 0);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
